// File: rtl/rom_read_arbiter_if.sv
// Bundle of signals between the requesters, the round-robin arbiter and the
// dual-port ROM. The slave modport is the arbiter's view. The master modport
// is the view of the requester/ROM side that surrounds it.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [ADDR_WIDTH-1:0]         rom_addr_a;
  logic [ADDR_WIDTH-1:0]         rom_addr_b;
  logic [DATA_WIDTH-1:0]         rom_q_a;
  logic [DATA_WIDTH-1:0]         rom_q_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  req_valid, req_addr, rom_q_a, rom_q_b,
    output req_ready, rom_addr_a, rom_addr_b, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, rom_q_a, rom_q_b,
    input  req_ready, rom_addr_a, rom_addr_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares the two ROM read ports among NUM_REQ
// requesters. Each cycle it grants up to two requests, one per port.
// Read data is returned to the owner two cycles after acceptance.
module rom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
) (
  input logic               clk,
  input logic               rst_n,
  rom_read_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         ptr_reg;
  logic [PW-1:0]         ptr_next;
  logic                  grant_a;
  logic                  grant_b;
  logic [PW-1:0]         win_a;
  logic [PW-1:0]         win_b;
  logic                  valid_a_reg;
  logic                  valid_b_reg;
  logic [PW-1:0]         id_a_reg;
  logic [PW-1:0]         id_b_reg;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  // Unpack the address bus so the port muxes can index by winner id.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Port A takes the first valid requester at or after ptr. Port B takes the
  // next valid requester after A's winner, so a requester never holds both.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    win_a   = '0;
    win_b   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_a && bus.req_valid[PW'((int'(ptr_reg) + k) % NUM_REQ)]) begin
        grant_a = 1'b1;
        win_a   = PW'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (grant_a && !grant_b && bus.req_valid[PW'((int'(win_a) + k) % NUM_REQ)]) begin
        grant_b = 1'b1;
        win_b   = PW'((int'(win_a) + k) % NUM_REQ);
      end
    end
  end

  // The pointer moves past the last winner so that served requesters go to the back of the queue.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_b) begin
      ptr_next = PW'((int'(win_b) + 1) % NUM_REQ);
    end else if (grant_a) begin
      ptr_next = PW'((int'(win_a) + 1) % NUM_REQ);
    end
  end

  // Grants and ROM addresses are suppressed while reset is asserted. An idle port drives address 0.
  assign bus.rom_addr_a = (rst_n && grant_a) ? addr_arr[win_a] : '0;
  assign bus.rom_addr_b = (rst_n && grant_b) ? addr_arr[win_b] : '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = rst_n && ((grant_a && (win_a == PW'(gi))) ||
                                         (grant_b && (win_b == PW'(gi))));
  end

  // Advance the pointer and tag which requester owns each in-flight ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= '0;
      valid_a_reg <= 1'b0;
      valid_b_reg <= 1'b0;
      id_a_reg    <= '0;
      id_b_reg    <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      valid_a_reg <= grant_a;
      valid_b_reg <= grant_b;
      id_a_reg    <= win_a;
      id_b_reg    <= win_b;
    end
  end

  // Per-requester response stage. It strobes when a tagged read returns and
  // otherwise holds the last data.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;

    // Capture ROM data from whichever port carried this requester's read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_valid_reg <= 1'b0;
        rsp_data_reg  <= '0;
      end else if (valid_a_reg && (id_a_reg == PW'(gi))) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= bus.rom_q_a;
      end else if (valid_b_reg && (id_b_reg == PW'(gi))) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= bus.rom_q_b;
      end else begin
        rsp_valid_reg <= 1'b0;
      end
    end

    assign bus.rsp_valid[gi]                          = rsp_valid_reg;
    assign bus.rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = rsp_data_reg;
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter, with a behavioural registered dual-port ROM.
module tb_rom_read_arbiter;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM contents: ROM[5] = 0xABC, and a scrambled pattern elsewhere.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = ({2'b00, a} * 12'd37) ^ 12'h5A5;
    return (a == 10'h005) ? 12'hABC : v;
  endfunction

  // Registered ROM read on both ports.
  always @(posedge clk) begin
    bus.rom_q_a <= rom_f(bus.rom_addr_a);
    bus.rom_q_b <= rom_f(bus.rom_addr_b);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rsp_slice(input int i);
    return bus.rsp_data[i*DW +: DW];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with every requester asking
    bus.req_valid = 4'b1111;
    bus.req_addr  = '0;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h010 + i));
    rst_n = 1'b0;
    step();
    step();
    check("reset_ready", bus.req_ready, 4'b0000);
    check("reset_rsp_valid", bus.rsp_valid, 4'b0000);
    check("reset_rsp_data", bus.rsp_data, 48'h0);
    check("reset_addr_a", bus.rom_addr_a, 10'h000);
    check("reset_addr_b", bus.rom_addr_b, 10'h000);
    rst_n = 1'b1;
    bus.req_valid = 4'b0000;

    // Single read from requester 2
    bus.req_valid = 4'b0100;
    set_addr(2, 10'h005);
    #1;
    check("single_ready", bus.req_ready, 4'b0100);
    check("single_addr_a", bus.rom_addr_a, 10'h005);
    check("single_addr_b", bus.rom_addr_b, 10'h000);
    step();
    bus.req_valid = 4'b0000;
    check("single_rsp_n1", bus.rsp_valid, 4'b0000);
    step();
    check("single_rsp_n2", bus.rsp_valid, 4'b0100);
    check("single_data", rsp_slice(2), 12'hABC);
    step();
    check("single_rsp_n3", bus.rsp_valid, 4'b0000);

    // Dual grants from reset
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h010 + i));
    #1;
    check("dual_c0_ready", bus.req_ready, 4'b0011);
    check("dual_c0_addr_a", bus.rom_addr_a, 10'h010);
    check("dual_c0_addr_b", bus.rom_addr_b, 10'h011);
    step();
    check("dual_c1_ready", bus.req_ready, 4'b1100);
    check("dual_c1_addr_a", bus.rom_addr_a, 10'h012);
    check("dual_c1_addr_b", bus.rom_addr_b, 10'h013);
    step();
    check("dual_c2_ready", bus.req_ready, 4'b0011);
    check("dual_c2_addr_a", bus.rom_addr_a, 10'h010);
    check("dual_c2_rsp", bus.rsp_valid, 4'b0011);
    check("dual_c2_d0", rsp_slice(0), rom_f(10'h010));
    check("dual_c2_d1", rsp_slice(1), rom_f(10'h011));
    step();
    check("dual_c3_ready", bus.req_ready, 4'b1100);
    check("dual_c3_rsp", bus.rsp_valid, 4'b1100);
    check("dual_c3_d2", rsp_slice(2), rom_f(10'h012));
    check("dual_c3_d3", rsp_slice(3), rom_f(10'h013));
    step();
    bus.req_valid = 4'b0000;
    check("dual_c4_rsp", bus.rsp_valid, 4'b0011);
    step();
    check("dual_c5_rsp", bus.rsp_valid, 4'b1100);
    step();
    check("dual_c6_rsp", bus.rsp_valid, 4'b0000);

    // Rotation with gaps: one grant to requester 0 moves ptr to 1
    bus.req_valid = 4'b0001;
    set_addr(0, 10'h030);
    set_addr(3, 10'h033);
    step();
    bus.req_valid = 4'b1001;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rot_c%0d_ready", c), bus.req_ready, 4'b1001);
      check($sformatf("rot_c%0d_addr_a", c), bus.rom_addr_a, 10'h033);
      check($sformatf("rot_c%0d_addr_b", c), bus.rom_addr_b, 10'h030);
      step();
    end
    bus.req_valid = 4'b0000;
    check("rot_rsp", bus.rsp_valid, 4'b1001);
    check("rot_d3", rsp_slice(3), rom_f(10'h033));
    step();
    step();

    // Reset in mid-flight
    bus.req_valid = 4'b0011;
    set_addr(0, 10'h040);
    set_addr(1, 10'h041);
    #1;
    check("mid_ready", bus.req_ready, 4'b0011);
    step();
    bus.req_valid = 4'b0000;
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("mid_rsp_n2", bus.rsp_valid, 4'b0000);
    check("mid_rsp_data0", rsp_slice(0), 12'h000);
    step();
    check("mid_rsp_n3", bus.rsp_valid, 4'b0000);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h050 + i));
    #1;
    check("mid_ptr_ready", bus.req_ready, 4'b0011);
    check("mid_ptr_addr_a", bus.rom_addr_a, 10'h050);
    bus.req_valid = 4'b0000;
    step();
    step();

    // Back-to-back streaming from requester 1
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        bus.req_valid = 4'b0010;
        set_addr(1, AW'(c));
      end else begin
        bus.req_valid = 4'b0000;
      end
      #1;
      if (c < 8) begin
        check($sformatf("stream_c%0d_ready", c), bus.req_ready, 4'b0010);
        check($sformatf("stream_c%0d_addr_a", c), bus.rom_addr_a, AW'(c));
        check($sformatf("stream_c%0d_addr_b", c), bus.rom_addr_b, 10'h000);
      end
      if (c >= 2) begin
        check($sformatf("stream_c%0d_rsp", c), bus.rsp_valid, 4'b0010);
        check($sformatf("stream_c%0d_data", c), rsp_slice(1), rom_f(AW'(c - 2)));
      end else begin
        check($sformatf("stream_c%0d_rsp", c), bus.rsp_valid, 4'b0000);
      end
      step();
    end
    check("stream_end_rsp", bus.rsp_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
